biu_arbiter: RTL and testbench
==============================

Name: biu_arbiter

Overview:
- Round-robin arbiter/scheduler sharing one biu_master (and so one bus_if) between NUM_REQ requesters that speak the BIU master protocol.
- Each requester fires a one-cycle en pulse. The arbiter latches the request, serialises the queued requests onto the single downstream BIU channel, and returns per-requester done/read data.
- Sits between application masters (switch pollers, DMA, CPU shim) and biu_master_inst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- req_en  in  NUM_REQ  per-requester start pulse; honoured only while that req_busy=0
- req_rnw  in  NUM_REQ  1=read, 0=write
- req_address  in  NUM_REQ*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_out  in  NUM_REQ*DATA_WIDTH  packed write data
- req_busy  out  NUM_REQ  request pending or in flight
- req_done  out  NUM_REQ  one-cycle completion pulse
- req_data_in  out  NUM_REQ*DATA_WIDTH  read data; holds until that requester's next read completes
- m_en  out  1  to biu_master en
- m_rnw  out  1  to biu_master rnw
- m_address  out  ADDR_WIDTH  to biu_master address
- m_data_out  out  DATA_WIDTH  to biu_master data_out
- m_busy  in  1  from biu_master busy
- m_data_in  in  DATA_WIDTH  from biu_master data_in; valid in the cycle m_busy falls

Behaviour:
- Reset values: all outputs 0. pending=0. State IDLE. rr_ptr=0. grant=0. All holding registers 0.
- Downstream contract: biu_master accepts m_en only when m_busy=0. It raises m_busy the cycle after acceptance and holds it until the transaction completes.
- Capture: req_en[i]=1 with pending[i]=0 latches rnw/address/data_out into holding register i and sets pending[i] next edge.
- req_busy[i] = pending[i] (registered). It rises the cycle after req_en.
- req_en[i] while pending[i]=1 is silently dropped. Holding register i is unchanged.
- FSM:
  - IDLE: if |pending and m_busy=0, choose winner and register grant -> ISSUE. Winner is the first pending index starting at rr_ptr, wrapping NUM_REQ-1 -> 0.
  - ISSUE: m_en=1 for exactly this one cycle, driven from holding[grant] -> WAIT_ACK.
  - WAIT_ACK: m_en=0; stay until m_busy=1 -> WAIT_DONE.
  - WAIT_DONE: on m_busy=0, do all of the following in one edge, then -> IDLE:
    - if read, req_data_in[grant] <= m_data_in
    - req_done[grant]=1 (one cycle, registered)
    - pending[grant] <= 0
    - rr_ptr <= grant+1, with NUM_REQ wrapping to 0
- m_rnw, m_address and m_data_out are driven from holding[grant] in every state; they are 0 in IDLE when nothing has been granted since reset.
- req_done[i] and the falling edge of req_busy[i] occur in the same cycle. The requester may re-request in the next cycle.
- New captures in any state are accepted; they only join arbitration in IDLE.
- Minimum request-to-done latency with an idle arbiter and a 1-cycle downstream busy: req_en at cycle 0, pending at 1, ISSUE at 2, busy high at 3, busy low at 4, done at 5.
- Back-to-back throughput: one transaction per (3 + downstream busy length) cycles.
- Reset mid-operation: everything returns to its reset value immediately. The in-flight transaction is abandoned with no req_done. biu_master shares n_rst.
- Write-only requesters must still see req_done. req_data_in is untouched on writes.

Optional Feature:
- Macro: BIU_ARB_FIXED_PRIORITY_EN.
- Defined: rr_ptr is removed. The winner is always the lowest pending index; starvation of high indices is permitted.
- Undefined: round-robin as above.

Test Plan:
- Single write: req_en[1] with addr 0xc0000000, data 0x12341234, downstream busy 2 cycles -> exactly one m_en pulse carrying those values; req_done[1] pulses once; req_data_in[1] unchanged; req_busy[1] falls with done.
- Single read: req 2 reads, m_data_in=0xdeadbeef on busy fall -> req_data_in[2]=0xdeadbeef from the cycle after done; other req_data_in unchanged.
- Contention: req_en=4'b1111 in one cycle from reset -> grant order 0,1,2,3. Then re-request all with rr_ptr=0 -> 0,1,2,3 again. Requesting 0 and 3 with rr_ptr=1 -> 3 then 0.
- Protocol: req_en[0] re-pulsed while req_busy[0]=1 with different addr 0x4 -> ignored; the original address is issued; one done only.
- Reset at WAIT_DONE: n_rst low for 1 cycle -> all outputs 0 asynchronously, no req_done, pending cleared; the next request completes normally.
- BIU_ARB_FIXED_PRIORITY_EN defined: requesters 0 and 3 requesting continuously -> requester 3 is never granted while 0 stays pending.

Source files
------------

// File: rtl/biu_arbiter.sv
// biu_arbiter: shares one biu_master between NUM_REQ requesters, round-robin by default.
// Define BIU_ARB_FIXED_PRIORITY_EN to make the lowest pending index always win (no rr pointer).
//
// state       | meaning
// S_IDLE      | wait for any pending request while biu_master is idle
// S_ISSUE     | m_en high for one cycle carrying holding[grant]
// S_WAIT_ACK  | wait for biu_master to raise busy
// S_WAIT_DONE | wait for busy to fall, then complete the granted requester
module biu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ-1:0]            req_rnw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_out,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic                          m_en,
  output logic                          m_rnw,
  output logic [ADDR_WIDTH-1:0]         m_address,
  output logic [DATA_WIDTH-1:0]         m_data_out,
  input  logic                          m_busy,
  input  logic [DATA_WIDTH-1:0]         m_data_in
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t                        r_state;
  logic [NUM_REQ-1:0]            r_pending;
  logic [NUM_REQ-1:0]            r_hold_rnw;
  logic [ADDR_WIDTH-1:0]         r_hold_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]         r_hold_data [NUM_REQ];
  logic [NUM_REQ-1:0]            r_req_done;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_req_data_in;
  logic [IW-1:0]                 r_grant;
  logic                          r_m_en;
  logic                          r_m_rnw;
  logic [ADDR_WIDTH-1:0]         r_m_addr;
  logic [DATA_WIDTH-1:0]         r_m_data;
  logic [IW-1:0]                 w_winner;

`ifdef BIU_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (r_pending[k]) w_winner = IW'(k);
  end
`else
  logic [IW-1:0] r_rr_ptr;
  logic          w_found;
  int            w_idx;

  // First pending index at or after r_rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && r_pending[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_hold_rnw    <= '0;
      r_req_done    <= '0;
      r_req_data_in <= '0;
      r_grant       <= '0;
      r_m_en        <= 1'b0;
      r_m_rnw       <= 1'b0;
      r_m_addr      <= '0;
      r_m_data      <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold_addr[i] <= '0;
        r_hold_data[i] <= '0;
      end
`ifndef BIU_ARB_FIXED_PRIORITY_EN
      r_rr_ptr      <= '0;
`endif
    end else begin
      r_req_done <= '0;

      // A requester already pending keeps its original request; repeats are dropped.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_en[i] && !r_pending[i]) begin
          r_pending[i]   <= 1'b1;
          r_hold_rnw[i]  <= req_rnw[i];
          r_hold_addr[i] <= req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_hold_data[i] <= req_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (|r_pending && !m_busy) begin
            r_grant  <= w_winner;
            r_m_en   <= 1'b1;
            r_m_rnw  <= r_hold_rnw[w_winner];
            r_m_addr <= r_hold_addr[w_winner];
            r_m_data <= r_hold_data[w_winner];
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_m_en  <= 1'b0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (m_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!m_busy) begin
            if (r_m_rnw) r_req_data_in[r_grant*DATA_WIDTH +: DATA_WIDTH] <= m_data_in;
            r_req_done[r_grant] <= 1'b1;
            r_pending[r_grant]  <= 1'b0;
`ifndef BIU_ARB_FIXED_PRIORITY_EN
            if (r_grant == IW'(NUM_REQ - 1)) r_rr_ptr <= '0;
            else                             r_rr_ptr <= r_grant + 1'b1;
`endif
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_busy    = r_pending;
  assign req_done    = r_req_done;
  assign req_data_in = r_req_data_in;
  assign m_en        = r_m_en;
  assign m_rnw       = r_m_rnw;
  assign m_address   = r_m_addr;
  assign m_data_out  = r_m_data;
endmodule

// File: tb/tb_biu_arbiter.sv
// tb_biu_arbiter: directed bench for biu_arbiter with a small biu_master responder model.
// Ordering expectations follow BIU_ARB_FIXED_PRIORITY_EN when it is defined.
module tb_biu_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic [N-1:0]    req_en = '0;
  logic [N-1:0]    req_rnw = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*DW-1:0] req_data_out = '0;
  logic [N-1:0]    req_busy;
  logic [N-1:0]    req_done;
  logic [N*DW-1:0] req_data_in;
  logic          m_en, m_rnw, m_busy;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data_out;
  logic [DW-1:0] m_data_in = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int blen    = 1;
  int bcnt    = 0;
  int n_iss   = 0;
  int n_men   = 0;
  int done_cnt [N];
  logic [AW-1:0] iss_addr [256];
  logic [DW-1:0] iss_data [256];
  logic          iss_rnw  [256];

  always #5 clk = ~clk;

  biu_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_en(req_en), .req_rnw(req_rnw), .req_address(req_address), .req_data_out(req_data_out),
    .req_busy(req_busy), .req_done(req_done), .req_data_in(req_data_in),
    .m_en(m_en), .m_rnw(m_rnw), .m_address(m_address), .m_data_out(m_data_out),
    .m_busy(m_busy), .m_data_in(m_data_in)
  );

  // biu_master model: accept en while idle, busy for blen cycles starting next cycle.
  assign m_busy = (bcnt != 0);
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)                    bcnt <= 0;
    else if (m_en && bcnt == 0)    bcnt <= blen;
    else if (bcnt != 0)            bcnt <= bcnt - 1;
  end

  always @(posedge clk) begin
    if (n_rst && m_en) begin
      n_men <= n_men + 1;
      if (!m_busy) begin
        iss_addr[n_iss] <= m_address;
        iss_data[n_iss] <= m_data_out;
        iss_rnw[n_iss]  <= m_rnw;
        n_iss <= n_iss + 1;
      end
    end
  end

  always @(posedge clk)
    if (n_rst)
      for (int i = 0; i < N; i++)
        if (req_done[i]) done_cnt[i] <= done_cnt[i] + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int total_done();
    int s = 0;
    for (int i = 0; i < N; i++) s += done_cnt[i];
    return s;
  endfunction

  task automatic wait_total(input int target, input string tag);
    int c = 0;
    while (total_done() < target && c < 300) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, 64'(total_done() >= target), 64'd1);
    tick();
    tick();
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rnw[i] = rnw;
    req_address[i*AW +: AW] = a;
    req_data_out[i*DW +: DW] = d;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    req_en = mask;
    tick();
    req_en = '0;
  endtask

  // Returns the cycle index (en cycle = 0) in which req_done[i] is seen high.
  task automatic latency(input int i, output int cyc);
    cyc = 1;
    while (!req_done[i] && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bd, bi, bm, bt, cyc;

    #1 n_rst = 1'b0;
    tick();
    tick();
    chk("rst_busy",    64'(req_busy), 0);
    chk("rst_done",    64'(req_done), 0);
    chk("rst_rdata",   64'(req_data_in[63:0]) | 64'(req_data_in[127:64]), 0);
    chk("rst_m_en",    64'(m_en), 0);
    chk("rst_m_rnw",   64'(m_rnw), 0);
    chk("rst_m_addr",  64'(m_address), 0);
    chk("rst_m_data",  64'(m_data_out), 0);
    n_rst = 1'b1;
    tick();

    // contention from reset, twice
    for (int r = 0; r < 2; r++) begin
      bi = n_iss;
      bt = total_done();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 * (i + 1), 32'ha0 + i);
      pulse(4'b1111);
      wait_total(bt + 4, "cont");
      chk("cont_issues", 64'(n_iss - bi), 4);
      for (int j = 0; j < N; j++) chk($sformatf("cont%0d_order%0d", r, j), 64'(iss_addr[bi + j]), 64'(32'h100 * (j + 1)));
    end

    // single write, 2-cycle downstream busy
    blen = 2;
    bd = done_cnt[1]; bi = n_iss; bm = n_men;
    set_req(1, 1'b0, 32'hc0000000, 32'h12341234);
    pulse(4'b0010);
    chk("wr_busy_rise", 64'(req_busy[1]), 1);
    latency(1, cyc);
    chk("wr_latency", 64'(cyc), 6);
    chk("wr_busy_fall", 64'(req_busy[1]), 0);
    tick(); tick();
    chk("wr_done_cnt", 64'(done_cnt[1] - bd), 1);
    chk("wr_m_en_cnt", 64'(n_men - bm), 1);
    chk("wr_addr", 64'(iss_addr[bi]), 64'h00000000c0000000);
    chk("wr_data", 64'(iss_data[bi]), 64'h0000000012341234);
    chk("wr_rnw", 64'(iss_rnw[bi]), 0);
    chk("wr_rdata_kept", 64'(req_data_in[1*DW +: DW]), 0);

    // single read, minimum latency
    blen = 1;
    m_data_in = 32'hdeadbeef;
    bi = n_iss;
    set_req(2, 1'b1, 32'h2000, 32'h0);
    pulse(4'b0100);
    latency(2, cyc);
    chk("rd_latency", 64'(cyc), 5);
    tick();
    chk("rd_data", 64'(req_data_in[2*DW +: DW]), 64'hdeadbeef);
    chk("rd_other0", 64'(req_data_in[0*DW +: DW]), 0);
    chk("rd_other1", 64'(req_data_in[1*DW +: DW]), 0);
    chk("rd_other3", 64'(req_data_in[3*DW +: DW]), 0);
    chk("rd_rnw", 64'(iss_rnw[bi]), 1);
    tick();

    // repeat pulse while busy is dropped
    bd = done_cnt[0]; bi = n_iss; bt = total_done();
    set_req(0, 1'b0, 32'h40, 32'h55);
    pulse(4'b0001);
    chk("proto_busy", 64'(req_busy[0]), 1);
    set_req(0, 1'b0, 32'h4, 32'h66);
    pulse(4'b0001);
    wait_total(bt + 1, "proto");
    tick(); tick();
    chk("proto_addr", 64'(iss_addr[bi]), 64'h40);
    chk("proto_data", 64'(iss_data[bi]), 64'h55);
    chk("proto_issues", 64'(n_iss - bi), 1);
    chk("proto_dones", 64'(done_cnt[0] - bd), 1);

    // requesters 0 and 3 together with rr_ptr at 1
    bi = n_iss; bt = total_done();
    set_req(0, 1'b0, 32'h500, 32'h1);
    set_req(3, 1'b0, 32'h800, 32'h2);
    pulse(4'b1001);
    wait_total(bt + 2, "pair");
`ifdef BIU_ARB_FIXED_PRIORITY_EN
    chk("pair_first",  64'(iss_addr[bi]),     64'h500);
    chk("pair_second", 64'(iss_addr[bi + 1]), 64'h800);
`else
    chk("pair_first",  64'(iss_addr[bi]),     64'h800);
    chk("pair_second", 64'(iss_addr[bi + 1]), 64'h500);
`endif

    // reset while waiting for busy to fall
    blen = 4;
    set_req(1, 1'b0, 32'h900, 32'h77);
    pulse(4'b0010);
    cyc = 0;
    while (!m_busy && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("mid_busy_seen", 64'(m_busy), 1);
    tick();
    bd = done_cnt[1];
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(req_busy), 0);
    chk("mid_rst_done",  64'(req_done), 0);
    chk("mid_rst_rdata", 64'(req_data_in[2*DW +: DW]), 0);
    chk("mid_rst_m_en",  64'(m_en), 0);
    chk("mid_rst_addr",  64'(m_address), 0);
    chk("mid_rst_data",  64'(m_data_out), 0);
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_no_done", 64'(done_cnt[1] - bd), 0);

    blen = 1;
    m_data_in = 32'hcafef00d;
    bi = n_iss; bt = total_done();
    set_req(1, 1'b1, 32'ha00, 32'h0);
    pulse(4'b0010);
    wait_total(bt + 1, "post");
    chk("post_addr", 64'(iss_addr[bi]), 64'ha00);
    chk("post_rdata", 64'(req_data_in[1*DW +: DW]), 64'hcafef00d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
